lock_code_checker: RTL and testbench

- Consumes the one-cycle, per-button rising-edge pulses from the N-bit button monitor (bus `buttonEdge`).
- Decodes each single press into a digit and accumulates a code of CODE_LENGTH digits.
- Compares the entered code with a stored code and drives the lock state, with a lockout after repeated failures.
- While unlocked, the user can relock or program a new code.

---
 rtl/lock_code_checker.sv | 160 ++++++++++++++++
 tb/tb_lock_code_checker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lock_code_checker.sv
// Lock code checker: decodes single-button press pulses into digits,
// gathers a CODE_LENGTH-digit entry, and compares it with the stored code.
// Repeated failures trigger a timed lockout. While unlocked the user can
// relock, or program a new code.
module lock_code_checker #(
  parameter int WIDTH          = 4,
  parameter int CODE_LENGTH    = 4,
  parameter int IDX_W          = $clog2(WIDTH),
  parameter logic [CODE_LENGTH*IDX_W-1:0] DEFAULT_CODE = 8'b11_10_01_00,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [WIDTH-1:0]                  buttonEdge,
  output logic                              locked,
  output logic                              error,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] failCount,
  output logic [$clog2(CODE_LENGTH+1)-1:0]  entryCount
);

  localparam int FC_W   = $clog2(MAX_ATTEMPTS+1);
  localparam int EC_W   = $clog2(CODE_LENGTH+1);
  localparam int CODE_W = CODE_LENGTH*IDX_W;
  localparam int LC_W   = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_LOCKED,
    S_CHECK,
    S_UNLOCKED,
    S_SET_CODE,
    S_LOCKOUT
  } state_t;

  state_t            state_q;
  logic              locked_q;
  logic              error_q;
  logic [FC_W-1:0]   fail_q;
  logic [EC_W-1:0]   entry_cnt_q;
  logic [CODE_W-1:0] entry_q;
  logic [CODE_W-1:0] code_q;
  logic [LC_W-1:0]   lock_cnt_q;

  int unsigned       press_n;
  logic [IDX_W-1:0]  press_idx;
  logic              valid_press;
  logic              last_digit;
  logic [CODE_W-1:0] entry_d;

  // Press decode: a press is valid only when exactly one button pulsed.
  always_comb begin
    press_n   = 0;
    press_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (buttonEdge[i]) begin
        press_n   = press_n + 1;
        press_idx = IDX_W'(i);
      end
    end
  end

  assign valid_press = (press_n == 1);
  assign last_digit  = (entry_cnt_q == EC_W'(CODE_LENGTH-1));

  // Entry register with the decoded digit dropped into the current slot.
  always_comb begin
    entry_d = entry_q;
    for (int s = 0; s < CODE_LENGTH; s++) begin
      if (entry_cnt_q == EC_W'(s)) entry_d[s*IDX_W +: IDX_W] = press_idx;
    end
  end

  // Lock FSM; all outputs registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_LOCKED;
      locked_q    <= 1'b1;
      error_q     <= 1'b0;
      fail_q      <= '0;
      entry_cnt_q <= '0;
      entry_q     <= '0;
      code_q      <= DEFAULT_CODE;
      lock_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_LOCKED: begin
          if (valid_press) begin
            entry_q     <= entry_d;
            entry_cnt_q <= entry_cnt_q + 1'b1;
            if (last_digit) state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Presses arriving during the compare cycle are dropped.
          entry_cnt_q <= '0;
          entry_q     <= '0;
          if (entry_q == code_q) begin
            state_q  <= S_UNLOCKED;
            locked_q <= 1'b0;
            fail_q   <= '0;
          end else if (fail_q == FC_W'(MAX_ATTEMPTS-1)) begin
            state_q    <= S_LOCKOUT;
            error_q    <= 1'b1;
            fail_q     <= FC_W'(MAX_ATTEMPTS);
            lock_cnt_q <= LC_W'(LOCKOUT_CYCLES-1);
          end else begin
            state_q <= S_LOCKED;
            fail_q  <= fail_q + 1'b1;
          end
        end
        S_LOCKOUT: begin
          // Count runs LOCKOUT_CYCLES-1 down to 0, so error is high that many cycles.
          if (lock_cnt_q == '0) begin
            state_q <= S_LOCKED;
            error_q <= 1'b0;
            fail_q  <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_q - 1'b1;
          end
        end
        S_UNLOCKED: begin
          if (valid_press) begin
            if (press_idx == IDX_W'(WIDTH-1)) begin
              state_q  <= S_LOCKED;
              locked_q <= 1'b1;
            end else if (press_idx == '0) begin
              state_q <= S_SET_CODE;
            end
          end
        end
        S_SET_CODE: begin
          if (valid_press) begin
            if (last_digit) begin
              // New code commits on the final digit; no compare needed.
              code_q      <= entry_d;
              entry_q     <= '0;
              entry_cnt_q <= '0;
              state_q     <= S_LOCKED;
              locked_q    <= 1'b1;
            end else begin
              entry_q     <= entry_d;
              entry_cnt_q <= entry_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q  <= S_LOCKED;
          locked_q <= 1'b1;
          error_q  <= 1'b0;
        end
      endcase
    end
  end

  assign locked     = locked_q;
  assign error      = error_q;
  assign failCount  = fail_q;
  assign entryCount = entry_cnt_q;

endmodule

// File: tb/tb_lock_code_checker.sv
// Bench for lock_code_checker: each scenario builds a plan of per-cycle
// stimulus and expected {locked, error, failCount, entryCount}, pushes the
// expectation to the scoreboard as the stimulus is driven, and pops it once
// the DUT has taken the clock edge.
module tb_lock_code_checker;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] buttonEdge = '0;
  logic       locked;
  logic       error;
  logic [1:0] failCount;
  logic [2:0] entryCount;

  typedef struct packed {
    logic       rst;
    logic [3:0] btn;
    logic [6:0] exp;
  } step_t;

  logic [6:0] sb[$];
  int vectors = 0;
  int miscompares = 0;

  lock_code_checker dut (
    .clock      (clock),
    .reset      (reset),
    .buttonEdge (buttonEdge),
    .locked     (locked),
    .error      (error),
    .failCount  (failCount),
    .entryCount (entryCount)
  );

  always #5 clock = ~clock;

  function automatic step_t st(logic r, logic [3:0] b, logic l, logic e,
                               logic [1:0] f, logic [2:0] c);
    return {r, b, l, e, f, c};
  endfunction

  localparam logic [3:0] B0 = 4'b0001, B1 = 4'b0010, B2 = 4'b0100, B3 = 4'b1000;

  task automatic test_reset();
    step_t plan[$];
    logic [6:0] got, want;
    plan.push_back(st(1, B0, 1, 0, 0, 0));
    plan.push_back(st(1, 4'b0, 1, 0, 0, 0));
    plan.push_back(st(0, 4'b0, 1, 0, 0, 0));
    foreach (plan[i]) begin
      reset = plan[i].rst; buttonEdge = plan[i].btn; sb.push_back(plan[i].exp);
      @(posedge clock); #1;
      reset = 1'b0; buttonEdge = '0;
      got = {locked, error, failCount, entryCount}; want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset step %0d: got l,e,f,c=%b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_unlock_default();
    step_t plan[$];
    logic [6:0] got, want;
    plan.push_back(st(0, B0, 1, 0, 0, 1));
    plan.push_back(st(0, 4'b0, 1, 0, 0, 1));
    plan.push_back(st(0, B1, 1, 0, 0, 2));
    plan.push_back(st(0, 4'b0, 1, 0, 0, 2));
    plan.push_back(st(0, B2, 1, 0, 0, 3));
    plan.push_back(st(0, 4'b0, 1, 0, 0, 3));
    plan.push_back(st(0, B3, 1, 0, 0, 4));   // CHECK cycle
    plan.push_back(st(0, 4'b0, 0, 0, 0, 0)); // unlocked two cycles after last edge
    plan.push_back(st(0, B3, 1, 0, 0, 0));   // relock
    foreach (plan[i]) begin
      reset = plan[i].rst; buttonEdge = plan[i].btn; sb.push_back(plan[i].exp);
      @(posedge clock); #1;
      reset = 1'b0; buttonEdge = '0;
      got = {locked, error, failCount, entryCount}; want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL unlock_default step %0d: got l,e,f,c=%b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_lockout();
    step_t plan[$];
    logic [6:0] got, want;
    for (int a = 0; a < 3; a++) begin
      for (int d = 0; d < 4; d++) plan.push_back(st(0, B3, 1, 0, 2'(a), 3'(d+1)));
      if (a < 2) plan.push_back(st(0, 4'b0, 1, 0, 2'(a+1), 0));
      else       plan.push_back(st(0, 4'b0, 1, 1, 3, 0)); // first lockout cycle
    end
    // 15 more lockout cycles with presses sprinkled in, all ignored
    for (int k = 0; k < 15; k++)
      plan.push_back(st(0, (k % 3 == 0) ? B0 : ((k % 3 == 1) ? B3 : 4'b0), 1, 1, 3, 0));
    plan.push_back(st(0, 4'b0, 1, 0, 0, 0));
    foreach (plan[i]) begin
      reset = plan[i].rst; buttonEdge = plan[i].btn; sb.push_back(plan[i].exp);
      @(posedge clock); #1;
      reset = 1'b0; buttonEdge = '0;
      got = {locked, error, failCount, entryCount}; want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL lockout step %0d: got l,e,f,c=%b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_multi_press();
    step_t plan[$];
    logic [6:0] got, want;
    plan.push_back(st(0, B0, 1, 0, 0, 1));
    plan.push_back(st(0, B1, 1, 0, 0, 2));
    plan.push_back(st(0, 4'b0110, 1, 0, 0, 2)); // two buttons: ignored
    plan.push_back(st(0, 4'b0, 1, 0, 0, 2));
    plan.push_back(st(0, B2, 1, 0, 0, 3));
    plan.push_back(st(0, B3, 1, 0, 0, 4));
    plan.push_back(st(0, 4'b0, 0, 0, 0, 0));
    plan.push_back(st(0, B1, 0, 0, 0, 0));      // button 1 while unlocked: no change
    plan.push_back(st(0, 4'b1001, 0, 0, 0, 0)); // multi-press while unlocked: no change
    plan.push_back(st(0, B3, 1, 0, 0, 0));
    foreach (plan[i]) begin
      reset = plan[i].rst; buttonEdge = plan[i].btn; sb.push_back(plan[i].exp);
      @(posedge clock); #1;
      reset = 1'b0; buttonEdge = '0;
      got = {locked, error, failCount, entryCount}; want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL multi_press step %0d: got l,e,f,c=%b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_set_code();
    step_t plan[$];
    logic [6:0] got, want;
    plan.push_back(st(0, B0, 1, 0, 0, 1));
    plan.push_back(st(0, B1, 1, 0, 0, 2));
    plan.push_back(st(0, B2, 1, 0, 0, 3));
    plan.push_back(st(0, B3, 1, 0, 0, 4));
    plan.push_back(st(0, 4'b0, 0, 0, 0, 0));
    plan.push_back(st(0, B0, 0, 0, 0, 0)); // into SET_CODE
    plan.push_back(st(0, B2, 0, 0, 0, 1));
    plan.push_back(st(0, B2, 0, 0, 0, 2));
    plan.push_back(st(0, B1, 0, 0, 0, 3));
    plan.push_back(st(0, B1, 1, 0, 0, 0)); // code 2,2,1,1 stored, locked
    plan.push_back(st(0, B0, 1, 0, 0, 1));
    plan.push_back(st(0, B1, 1, 0, 0, 2));
    plan.push_back(st(0, B2, 1, 0, 0, 3));
    plan.push_back(st(0, B3, 1, 0, 0, 4));
    plan.push_back(st(0, 4'b0, 1, 0, 1, 0)); // old code now fails
    plan.push_back(st(0, B2, 1, 0, 1, 1));
    plan.push_back(st(0, B2, 1, 0, 1, 2));
    plan.push_back(st(0, B1, 1, 0, 1, 3));
    plan.push_back(st(0, B1, 1, 0, 1, 4));
    plan.push_back(st(0, 4'b0, 0, 0, 0, 0)); // new code unlocks, failCount cleared
    plan.push_back(st(0, B3, 1, 0, 0, 0));
    foreach (plan[i]) begin
      reset = plan[i].rst; buttonEdge = plan[i].btn; sb.push_back(plan[i].exp);
      @(posedge clock); #1;
      reset = 1'b0; buttonEdge = '0;
      got = {locked, error, failCount, entryCount}; want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL set_code step %0d: got l,e,f,c=%b want %b", i, got, want);
      end
    end
  endtask

  // Starts with stored code 2,2,1,1 left by test_set_code.
  task automatic test_reset_mid();
    step_t plan[$];
    logic [6:0] got, want;
    plan.push_back(st(0, B0, 1, 0, 0, 1));
    plan.push_back(st(0, B1, 1, 0, 0, 2));
    plan.push_back(st(1, B2, 1, 0, 0, 0));   // reset mid-entry, restores default code
    plan.push_back(st(0, B0, 1, 0, 0, 1));
    plan.push_back(st(0, B1, 1, 0, 0, 2));
    plan.push_back(st(0, B2, 1, 0, 0, 3));
    plan.push_back(st(0, B3, 1, 0, 0, 4));
    plan.push_back(st(0, 4'b0, 0, 0, 0, 0));
    plan.push_back(st(0, B0, 0, 0, 0, 0));   // SET_CODE
    plan.push_back(st(0, B2, 0, 0, 0, 1));
    plan.push_back(st(0, B2, 0, 0, 0, 2));
    plan.push_back(st(1, 4'b0, 1, 0, 0, 0)); // reset mid-programming
    plan.push_back(st(0, B0, 1, 0, 0, 1));
    plan.push_back(st(0, B1, 1, 0, 0, 2));
    plan.push_back(st(0, B2, 1, 0, 0, 3));
    plan.push_back(st(0, B3, 1, 0, 0, 4));
    plan.push_back(st(0, 4'b0, 0, 0, 0, 0));
    plan.push_back(st(0, B3, 1, 0, 0, 0));
    plan.push_back(st(0, B0, 1, 0, 0, 1));
    plan.push_back(st(0, B1, 1, 0, 0, 2));
    plan.push_back(st(0, B2, 1, 0, 0, 3));
    plan.push_back(st(1, B3, 1, 0, 0, 0));   // last digit with reset: reset wins
    plan.push_back(st(0, 4'b0, 1, 0, 0, 0));
    for (int a = 0; a < 3; a++) begin
      for (int d = 0; d < 4; d++) plan.push_back(st(0, B3, 1, 0, 2'(a), 3'(d+1)));
      if (a < 2) plan.push_back(st(0, 4'b0, 1, 0, 2'(a+1), 0));
      else       plan.push_back(st(0, 4'b0, 1, 1, 3, 0));
    end
    for (int k = 0; k < 3; k++) plan.push_back(st(0, 4'b0, 1, 1, 3, 0));
    plan.push_back(st(1, 4'b0, 1, 0, 0, 0)); // reset mid-lockout
    plan.push_back(st(0, 4'b0, 1, 0, 0, 0));
    foreach (plan[i]) begin
      reset = plan[i].rst; buttonEdge = plan[i].btn; sb.push_back(plan[i].exp);
      @(posedge clock); #1;
      reset = 1'b0; buttonEdge = '0;
      got = {locked, error, failCount, entryCount}; want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset_mid step %0d: got l,e,f,c=%b want %b", i, got, want);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clock);
    test_reset();
    test_unlock_default();
    test_lockout();
    test_multi_press();
    test_set_code();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
